cr_xp10_decomp_lz77_hb_arb: RTL and testbench
=============================================

Name: cr_xp10_decomp_lz77_hb_arb

Overview:
- Sequences and arbitrates the single write port of the LZ77 history buffer (HB) between two requesters.
- Requester 1 is the data-out stage: 128-bit history writes that cannot be refused.
- Requester 2 is the prefix loader: preset-dictionary writes issued before a frame's data, using req/gnt.
- The block generates the HB write address with wrap-around, absorbs data-out writes in a skid FIFO, and backpressures the data-out stage.

Parameters:
- HB_DEPTH, 1024, number of 128-bit HB entries; power of two.
- ADDR_W, 10, log2(HB_DEPTH).
- SKID_DEPTH, 4, entries in the data-out skid FIFO; minimum 4.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- do_hb_wr  input  1  data-out history write strobe; never refused
- do_hb_wdata  input  128  data-out history write data
- pf_hb_req  input  1  prefix-loader write request
- pf_hb_wdata  input  128  prefix write data
- pf_hb_last  input  1  qualifies pf_hb_req; final prefix word
- pf_hb_gnt  output  1  combinational grant; the prefix word is consumed this cycle
- hb_frame_start  input  1  single-cycle pulse; new frame, restart addressing
- hb_busy  input  1  HB port unavailable this cycle (read collision)
- hb_wen  output  1  registered HB write enable
- hb_waddr  output  ADDR_W  registered HB write address
- hb_wdata  output  128  registered HB write data
- hb_arb_pause  output  1  registered backpressure to the data-out stage
- hb_wrapped  output  1  sticky: write pointer has wrapped this frame
- hb_fill  output  ADDR_W+1  valid entries this frame; saturates at HB_DEPTH
- hb_arb_overflow  output  1  sticky: a skid write was dropped

Behaviour:
- Reset: synchronous on rst_n=0 at posedge clk. All outputs 0, state IDLE, skid empty, wptr 0, frame-pending flag 0. Reset mid-frame discards skid contents and any pending frame start.
- Skid FIFO: every do_hb_wr=1 cycle pushes do_hb_wdata.
  - Push when full: data dropped, hb_arb_overflow set, FIFO contents unchanged.
  - Push and pop in the same cycle are allowed when full.
- Pause: hb_arb_pause is the registered value of (skid occupancy after this cycle >= SKID_DEPTH-2).
- Issue rule: at most one write per cycle, and none while hb_busy=1. An issued write registers hb_wen=1, hb_waddr=wptr and the selected data at the next edge. wptr then increments.
- Latency: do_hb_wr sampled at edge N reaches hb_wen at edge N+1 at the earliest, when the skid is empty and the port is free.
- States:
  - IDLE, with pf_hb_req=1 and !hb_busy: grant pf. Go to DATA if pf_hb_last, else to PREFIX. pf beats a non-empty skid, because the prefix must precede data in the history.
  - IDLE, with no pf request, skid non-empty and !hb_busy: pop the skid and go to DATA.
  - PREFIX: only pf is granted while the skid accumulates. A granted pf_hb_last moves to DATA.
  - DATA: the skid head is issued whenever non-empty and !hb_busy. pf_hb_gnt is held at 0.
- pf_hb_gnt = pf_hb_req && !hb_busy && state∈{IDLE,PREFIX} && !frame-pending.
- Frame start:
  - hb_frame_start sets frame-pending.
  - frame-pending takes effect in the first cycle with skid empty and no write issued. Effect: wptr=0, hb_fill=0, hb_wrapped=0, hb_arb_overflow=0, state IDLE, frame-pending cleared.
  - A pulse that arrives while already pending is ignored.
  - A pulse in the same cycle as the last skid pop takes effect the following cycle.
- Address arithmetic: wptr is ADDR_W bits and wraps from HB_DEPTH-1 to 0. On the wrap, hb_wrapped is set.
- hb_fill increments per issued write and saturates at HB_DEPTH.
- hb_wdata is held at its last value when hb_wen=0.

Test Plan:
- Reset, then 3 back-to-back do_hb_wr with data A,B,C and hb_busy=0 → hb_wen high 3 consecutive cycles starting 1 cycle later; addresses 0,1,2; data A,B,C; hb_fill=3; hb_arb_pause stays 0.
- Simultaneous IDLE pf_hb_req (P0, P1 with last) and do_hb_wr D0 → writes P0@0, P1@1, D0@2. pf_hb_gnt is high 2 cycles. D0 is held in the skid during PREFIX.
- hb_busy=1 for 10 cycles while do_hb_wr is high every cycle (SKID_DEPTH=4) → hb_arb_pause=1 once occupancy reaches 2. The 5th push sets hb_arb_overflow and exactly 4 words are later written in order.
- 1025 writes with HB_DEPTH=1024 → the 1025th write goes to address 0; hb_wrapped=1; hb_fill=1024.
- hb_frame_start pulsed with 3 words in the skid → all 3 are written at the continuing addresses, then wptr=0, hb_fill=0, hb_wrapped=0, and the next write goes to address 0.
- rst_n=0 mid-PREFIX with the skid non-empty → all outputs 0 the next cycle, no further hb_wen, and a new pf_hb_req is granted immediately after reset.

Source files
------------

// File: rtl/cr_xp10_decomp_lz77_hb_arb.sv
// LZ77 history-buffer write-port arbiter. Sequences prefix-loader and data-out writes,
// generates the wrapping write address and tracks per-frame fill and wrap state.
module cr_xp10_decomp_lz77_hb_arb #(
  parameter int HB_DEPTH   = 1024,
  parameter int ADDR_W     = 10,
  parameter int SKID_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              do_hb_wr,
  input  logic [127:0]      do_hb_wdata,
  input  logic              pf_hb_req,
  input  logic [127:0]      pf_hb_wdata,
  input  logic              pf_hb_last,
  output logic              pf_hb_gnt,
  input  logic              hb_frame_start,
  input  logic              hb_busy,
  output logic              hb_wen,
  output logic [ADDR_W-1:0] hb_waddr,
  output logic [127:0]      hb_wdata,
  output logic              hb_arb_pause,
  output logic              hb_wrapped,
  output logic [ADDR_W:0]   hb_fill,
  output logic              hb_arb_overflow
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(SKID_DEPTH);
  localparam logic [CNT_W-1:0]  PAUSE_CNT = CNT_W'(SKID_DEPTH - 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HB_DEPTH - 1);
  localparam logic [ADDR_W:0]   FILL_MAX  = (ADDR_W + 1)'(HB_DEPTH);

  typedef enum logic [1:0] {IDLE, PREFIX, DATA} state_t;

  state_t              state_reg, state_next;
  logic [127:0]        skid_mem [SKID_DEPTH];
  logic [PTR_W-1:0]    rd_idx_reg, wr_idx_reg;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ADDR_W-1:0]   wptr_reg;
  logic                pending_reg;

  logic                skid_empty;
  logic                pop;
  logic                issue;
  logic                push_acc;
  logic                drop;
  logic                frame_apply;
  logic [127:0]        issue_data;

  function automatic logic [PTR_W-1:0] idx_inc(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(SKID_DEPTH - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    skid_empty = (cnt_reg == '0);
    pf_hb_gnt  = pf_hb_req && !hb_busy && !pending_reg &&
                 ((state_reg == IDLE) || (state_reg == PREFIX));
    case (state_reg)
      IDLE: begin
        // A pending frame start blocks prefix grants, so the skid must still drain.
        if (pf_hb_gnt) begin
          state_next = pf_hb_last ? DATA : PREFIX;
        end else if (!skid_empty && !hb_busy && (!pf_hb_req || pending_reg)) begin
          pop        = 1'b1;
          state_next = DATA;
        end
      end
      PREFIX: begin
        if (pf_hb_gnt && pf_hb_last) state_next = DATA;
      end
      DATA: begin
        pop = !skid_empty && !hb_busy;
      end
      default: state_next = IDLE;
    endcase
    issue       = pf_hb_gnt || pop;
    issue_data  = pf_hb_gnt ? pf_hb_wdata : skid_mem[rd_idx_reg];
    frame_apply = pending_reg && skid_empty && !issue;
    if (frame_apply) state_next = IDLE;
  end

  // A full skid still accepts a push when the head leaves in the same cycle.
  assign push_acc = do_hb_wr && ((cnt_reg != FULL_CNT) || pop);
  assign drop     = do_hb_wr && (cnt_reg == FULL_CNT) && !pop;
  assign cnt_next = cnt_reg + CNT_W'(push_acc) - CNT_W'(pop);

  always_ff @(posedge clk) begin
    if (push_acc) skid_mem[wr_idx_reg] <= do_hb_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      rd_idx_reg      <= '0;
      wr_idx_reg      <= '0;
      cnt_reg         <= '0;
      wptr_reg        <= '0;
      pending_reg     <= 1'b0;
      hb_wen          <= 1'b0;
      hb_waddr        <= '0;
      hb_wdata        <= '0;
      hb_arb_pause    <= 1'b0;
      hb_wrapped      <= 1'b0;
      hb_fill         <= '0;
      hb_arb_overflow <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      hb_arb_pause <= (cnt_next >= PAUSE_CNT);
      if (push_acc) wr_idx_reg <= idx_inc(wr_idx_reg);
      if (pop)      rd_idx_reg <= idx_inc(rd_idx_reg);

      hb_wen <= issue;
      if (issue) begin
        hb_waddr <= wptr_reg;
        hb_wdata <= issue_data;
      end

      if (frame_apply) begin
        wptr_reg        <= '0;
        hb_fill         <= '0;
        hb_wrapped      <= 1'b0;
        hb_arb_overflow <= 1'b0;
        pending_reg     <= 1'b0;
      end else begin
        if (issue) begin
          wptr_reg <= wptr_reg + ADDR_W'(1);
          if (wptr_reg == LAST_ADDR) hb_wrapped <= 1'b1;
          if (hb_fill != FILL_MAX) hb_fill <= hb_fill + (ADDR_W + 1)'(1);
        end
        if (drop)           hb_arb_overflow <= 1'b1;
        if (hb_frame_start) pending_reg     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cr_xp10_decomp_lz77_hb_arb.sv
// Bench for the HB write arbiter: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model of the arbitration rules.
module tb_cr_xp10_decomp_lz77_hb_arb;
  localparam int HB_DEPTH   = 1024;
  localparam int ADDR_W     = 10;
  localparam int SKID_DEPTH = 4;
  localparam int M_IDLE = 0, M_PREFIX = 1, M_DATA = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              do_hb_wr = 1'b0;
  logic [127:0]      do_hb_wdata = '0;
  logic              pf_hb_req = 1'b0;
  logic [127:0]      pf_hb_wdata = '0;
  logic              pf_hb_last = 1'b0;
  logic              pf_hb_gnt;
  logic              hb_frame_start = 1'b0;
  logic              hb_busy = 1'b0;
  logic              hb_wen;
  logic [ADDR_W-1:0] hb_waddr;
  logic [127:0]      hb_wdata;
  logic              hb_arb_pause;
  logic              hb_wrapped;
  logic [ADDR_W:0]   hb_fill;
  logic              hb_arb_overflow;

  cr_xp10_decomp_lz77_hb_arb #(
    .HB_DEPTH(HB_DEPTH), .ADDR_W(ADDR_W), .SKID_DEPTH(SKID_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .do_hb_wr(do_hb_wr), .do_hb_wdata(do_hb_wdata),
    .pf_hb_req(pf_hb_req), .pf_hb_wdata(pf_hb_wdata), .pf_hb_last(pf_hb_last),
    .pf_hb_gnt(pf_hb_gnt),
    .hb_frame_start(hb_frame_start), .hb_busy(hb_busy),
    .hb_wen(hb_wen), .hb_waddr(hb_waddr), .hb_wdata(hb_wdata),
    .hb_arb_pause(hb_arb_pause), .hb_wrapped(hb_wrapped), .hb_fill(hb_fill),
    .hb_arb_overflow(hb_arb_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int gnt_seen = 0;
  int wen_seen = 0;

  // Behavioural model state
  logic [127:0] skid_q[$];
  int           m_mode, m_wptr, m_fill;
  bit           m_wrapped, m_ovf, m_pend, m_gnt;
  bit           e_wen, e_pause;
  int           e_waddr;
  logic [127:0] e_wdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    skid_q.delete();
    m_mode = M_IDLE; m_wptr = 0; m_fill = 0;
    m_wrapped = 0; m_ovf = 0; m_pend = 0; m_gnt = 0;
    e_wen = 0; e_pause = 0; e_waddr = 0; e_wdata = '0;
  endtask

  task automatic model_step(input bit dw, input logic [127:0] dd, input bit pr,
                            input logic [127:0] pd, input bit pl, input bit fs, input bit bz);
    bit take_skid, apply;
    logic [127:0] word;
    m_gnt = pr && !bz && (m_mode != M_DATA) && !m_pend;
    take_skid = 0;
    if (!m_gnt && !bz && skid_q.size() > 0)
      take_skid = (m_mode == M_DATA) || (m_mode == M_IDLE && (!pr || m_pend));
    apply = m_pend && skid_q.size() == 0 && !m_gnt && !take_skid;
    word = '0;
    if (m_gnt) begin
      word = pd;
      m_mode = pl ? M_DATA : M_PREFIX;
    end else if (take_skid) begin
      word = skid_q.pop_front();
      m_mode = M_DATA;
    end
    if (dw) begin
      if (skid_q.size() < SKID_DEPTH) skid_q.push_back(dd);
      else m_ovf = 1;
    end
    e_wen = m_gnt || take_skid;
    if (e_wen) begin
      e_waddr = m_wptr;
      e_wdata = word;
      m_wptr  = (m_wptr + 1) % HB_DEPTH;
      if (m_wptr == 0) m_wrapped = 1;
      if (m_fill < HB_DEPTH) m_fill++;
    end
    if (apply) begin
      m_wptr = 0; m_fill = 0; m_wrapped = 0; m_ovf = 0; m_mode = M_IDLE; m_pend = 0;
    end else if (fs) begin
      m_pend = 1;
    end
    e_pause = skid_q.size() >= SKID_DEPTH - 2;
  endtask

  task automatic tick(input bit rst, input bit dw, input logic [127:0] dd, input bit pr,
                      input logic [127:0] pd, input bit pl, input bit fs, input bit bz);
    rst_n = !rst; do_hb_wr = dw; do_hb_wdata = dd;
    pf_hb_req = pr; pf_hb_wdata = pd; pf_hb_last = pl;
    hb_frame_start = fs; hb_busy = bz;
    #3;
    if (rst) begin
      model_reset();
    end else begin
      model_step(dw, dd, pr, pd, pl, fs, bz);
      chk("pf_gnt", pf_hb_gnt, m_gnt);
    end
    if (pf_hb_gnt === 1'b1) gnt_seen++;
    @(posedge clk);
    #1;
    if (hb_wen === 1'b1) wen_seen++;
    chk("wen", hb_wen, e_wen);
    chk("waddr", hb_waddr, e_waddr);
    chk("wdata", hb_wdata, e_wdata);
    chk("pause", hb_arb_pause, e_pause);
    chk("wrapped", hb_wrapped, m_wrapped);
    chk("fill", hb_fill, m_fill);
    chk("overflow", hb_arb_overflow, m_ovf);
    $display("t=%0t rst=%0b dw=%0b pr=%0b fs=%0b bz=%0b -> wen=%0b addr=%0d fill=%0d pause=%0b",
             $time, rst, dw, pr, fs, bz, hb_wen, hb_waddr, hb_fill, hb_arb_pause);
  endtask

  task automatic idle(input bit bz);
    tick(0, 0, '0, 0, '0, 0, 0, bz);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    bit found;
    model_reset();
    tick(1, 0, '0, 0, '0, 0, 0, 0);
    tick(1, 0, '0, 0, '0, 0, 0, 0);
    chk("rst_wen", hb_wen, 0);
    chk("rst_fill", hb_fill, 0);

    // Back-to-back data-out writes A, B, C
    wen_seen = 0;
    tick(0, 1, 128'hA, 0, '0, 0, 0, 0);
    chk("t1_latency", hb_wen, 0);
    tick(0, 1, 128'hB, 0, '0, 0, 0, 0);
    chk("t1_first_wen", hb_wen, 1);
    tick(0, 1, 128'hC, 0, '0, 0, 0, 0);
    repeat (3) idle(0);
    chk("t1_wen_count", wen_seen, 3);
    chk("t1_fill", hb_fill, 3);

    // Prefix beats a simultaneous data-out word
    tick(1, 0, '0, 0, '0, 0, 0, 0);
    gnt_seen = 0;
    tick(0, 1, 128'hD0, 1, 128'hF0, 0, 0, 0);
    tick(0, 0, '0, 1, 128'hF1, 1, 0, 0);
    chk("t2_p1_addr", hb_waddr, 1);
    repeat (3) idle(0);
    chk("t2_gnt_cycles", gnt_seen, 2);
    chk("t2_d0_addr", hb_waddr, 2);
    chk("t2_d0_data", hb_wdata, 128'hD0);

    // Busy port fills and overflows the skid
    for (int i = 0; i < 10; i++) tick(0, 1, 128'h100 + 128'(i), 0, '0, 0, 0, 1);
    chk("t3_overflow", hb_arb_overflow, 1);
    chk("t3_pause", hb_arb_pause, 1);
    wen_seen = 0;
    repeat (6) idle(0);
    chk("t3_drained", wen_seen, 4);
    chk("t3_last_data", hb_wdata, 128'h103);

    // Frame start with three words in the skid
    for (int i = 0; i < 3; i++) tick(0, 1, 128'h200 + 128'(i), 0, '0, 0, 0, 1);
    tick(0, 0, '0, 0, '0, 0, 1, 1);
    repeat (6) idle(0);
    chk("t4_fill_cleared", hb_fill, 0);
    chk("t4_ovf_cleared", hb_arb_overflow, 0);
    tick(0, 1, 128'h300, 0, '0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      idle(0);
      if (hb_wen === 1'b1) found = 1;
    end
    chk("t4_wr_seen", found, 1);
    chk("t4_addr0", hb_waddr, 0);

    // Wrap: restart the frame, then HB_DEPTH+1 writes
    tick(0, 0, '0, 0, '0, 0, 1, 0);
    repeat (2) idle(0);
    for (int i = 0; i < HB_DEPTH + 1; i++) tick(0, 1, rnd128(), 0, '0, 0, 0, 0);
    repeat (3) idle(0);
    chk("t5_wrapped", hb_wrapped, 1);
    chk("t5_fill_sat", hb_fill, HB_DEPTH);
    chk("t5_last_addr", hb_waddr, 0);

    // Reset in the middle of a prefix load with skid contents
    tick(1, 0, '0, 0, '0, 0, 0, 0);
    tick(0, 0, '0, 1, 128'hE0, 0, 0, 0);
    tick(0, 1, 128'hE1, 0, '0, 0, 0, 0);
    tick(0, 1, 128'hE2, 0, '0, 0, 0, 0);
    tick(1, 0, '0, 0, '0, 0, 0, 0);
    chk("t6_rst_wen", hb_wen, 0);
    chk("t6_rst_wdata", hb_wdata, 0);
    wen_seen = 0;
    repeat (3) idle(0);
    chk("t6_no_wen", wen_seen, 0);
    tick(0, 0, '0, 1, 128'hE5, 1, 0, 0);
    chk("t6_regrant_wen", hb_wen, 1);
    chk("t6_regrant_data", hb_wdata, 128'hE5);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      tick(0, $urandom_range(0, 99) < 45, rnd128(),
           $urandom_range(0, 99) < 30, rnd128(), $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20);
    end
    repeat (8) idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
